// File: rtl/serial_sum_collector_if.sv
// Bundles the serial adder stream, the result handshake and status flags
// of serial_sum_collector into one port.
interface serial_sum_collector_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             bit_valid;
  logic             sum_bit;
  logic             carry_bit;
  logic             res_ready;
  logic             clr_err;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             busy;
  logic             overrun;

  // master: the adder/consumer side driving the collector
  modport master (
    output start, bit_valid, sum_bit, carry_bit, res_ready, clr_err,
    input  res_valid, res_sum, res_cout, busy, overrun
  );

  // slave: the collector itself
  modport slave (
    input  start, bit_valid, sum_bit, carry_bit, res_ready, clr_err,
    output res_valid, res_sum, res_cout, busy, overrun
  );
endinterface

// File: rtl/serial_sum_collector.sv
// Collects an LSB-first serial sum plus final carry into parallel words and
// queues completed results in a 2-entry valid/ready FIFO.
module serial_sum_collector #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_sum_collector_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } result_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  result_t          mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             overrun_q;

  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic [WIDTH-1:0] assembled;
  result_t          head;

  assign assembled = {bus.sum_bit, shreg[WIDTH-1:1]};
  // start has priority, so a bit strobed alongside it never completes a word
  assign push      = (state == COLLECT) && !bus.start && bus.bit_valid && (cnt == LAST);
  assign full      = (count == 2'd2);
  assign pop       = (count != 2'd0) && bus.res_ready;
  assign push_ok   = push && (!full || pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= COLLECT;
            cnt   <= '0;
            shreg <= '0;
          end
        end
        COLLECT: begin
          if (bus.start) begin
            cnt   <= '0;
            shreg <= '0;
          end else if (bus.bit_valid) begin
            if (cnt == LAST) begin
              state <= IDLE;
              cnt   <= '0;
              shreg <= '0;
            end else begin
              shreg <= assembled;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: queue storage is deliberately left unreset; the outputs are masked
  // by count, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{sum: assembled, cout: bus.carry_bit};
    end
  end

  // When full, wr_ptr == rd_ptr: a simultaneous pop frees exactly the slot written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_err) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.res_valid = (count != 2'd0);
  assign bus.res_sum   = bus.res_valid ? head.sum  : '0;
  assign bus.res_cout  = bus.res_valid ? head.cout : 1'b0;
  assign bus.busy      = (state == COLLECT);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed self-checking bench for serial_sum_collector (WIDTH=4).
module tb_serial_sum_collector;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  serial_sum_collector_if #(.WIDTH(4)) bus ();

  serial_sum_collector #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; land 1 time unit after it for drive and sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.sum_bit   = 1'b0;
    bus.carry_bit = 1'b0;
    bus.res_ready = 1'b0;
    bus.clr_err   = 1'b0;
  endtask

  // start pulse followed by four consecutive bits, LSB first
  task automatic send(input logic [3:0] val, input logic cout, input logic ready_last);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.bit_valid = 1'b1;
      bus.sum_bit   = val[i];
      bus.carry_bit = (i == 3) ? cout : 1'b0;
      if (i == 3 && ready_last) bus.res_ready = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
    bus.sum_bit   = 1'b0;
    bus.carry_bit = 1'b0;
    if (ready_last) bus.res_ready = 1'b0;
  endtask

  task automatic pop_one();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #12;
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout, bus.busy, bus.overrun} !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b busy=%b ovr=%b expected all 0",
               bus.res_valid, bus.res_sum, bus.res_cout, bus.busy, bus.overrun);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add_5_6();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: got %b expected 1", bus.busy);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      v = 4'hB;
      bus.bit_valid = 1'b1;
      bus.sum_bit   = v[i];
      bus.carry_bit = 1'b0;
      tick();
    end
    bus.bit_valid = 1'b0;
    bus.sum_bit   = 1'b0;
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout, bus.busy} !== {1'b1, 4'hB, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL add_5_6: got valid=%b sum=%h cout=%b busy=%b expected 1 b 0 0",
               bus.res_valid, bus.res_sum, bus.res_cout, bus.busy);
    end
    pop_one();
    tests++;
    if (bus.res_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_5_6_pop: got valid=%b expected 0", bus.res_valid);
    end
  endtask

  task automatic test_add_9_8();
    send(4'h1, 1'b1, 1'b0);
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout} !== {1'b1, 4'h1, 1'b1}) begin
      fails++;
      $display("FAIL add_9_8: got valid=%b sum=%h cout=%b expected 1 1 1",
               bus.res_valid, bus.res_sum, bus.res_cout);
    end
    pop_one();
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout} !== 6'b0) begin
      fails++;
      $display("FAIL add_9_8_empty: got valid=%b sum=%h cout=%b expected 0 0 0",
               bus.res_valid, bus.res_sum, bus.res_cout);
    end
  endtask

  task automatic test_backpressure();
    send(4'h3, 1'b0, 1'b0);
    send(4'h7, 1'b0, 1'b0);
    tests++;
    if (bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL bp_no_overrun_yet: got %b expected 0", bus.overrun);
    end
    send(4'hC, 1'b0, 1'b0);
    tick();
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.overrun} !== {1'b1, 4'h3, 1'b1}) begin
      fails++;
      $display("FAIL bp_full: got valid=%b sum=%h ovr=%b expected 1 3 1",
               bus.res_valid, bus.res_sum, bus.overrun);
    end
    tests++;
    if (bus.res_sum !== 4'h3) begin
      fails++;
      $display("FAIL bp_head_stable: got %h expected 3", bus.res_sum);
    end
    pop_one();
    tests++;
    if ({bus.res_valid, bus.res_sum} !== {1'b1, 4'h7}) begin
      fails++;
      $display("FAIL bp_pop1: got valid=%b sum=%h expected 1 7", bus.res_valid, bus.res_sum);
    end
    pop_one();
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.overrun} !== {1'b0, 4'h0, 1'b1}) begin
      fails++;
      $display("FAIL bp_pop2: got valid=%b sum=%h ovr=%b expected 0 0 1",
               bus.res_valid, bus.res_sum, bus.overrun);
    end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    tests++;
    if (bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL bp_clr_err: got %b expected 0", bus.overrun);
    end
  endtask

  task automatic test_full_pop();
    send(4'h2, 1'b0, 1'b0);
    send(4'h5, 1'b1, 1'b0);
    send(4'h9, 1'b0, 1'b1);
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout, bus.overrun} !== {1'b1, 4'h5, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL full_pop_head: got valid=%b sum=%h cout=%b ovr=%b expected 1 5 1 0",
               bus.res_valid, bus.res_sum, bus.res_cout, bus.overrun);
    end
    pop_one();
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout} !== {1'b1, 4'h9, 1'b0}) begin
      fails++;
      $display("FAIL full_pop_next: got valid=%b sum=%h cout=%b expected 1 9 0",
               bus.res_valid, bus.res_sum, bus.res_cout);
    end
    // one entry held, next result lands with a simultaneous pop
    send(4'h6, 1'b1, 1'b1);
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout} !== {1'b1, 4'h6, 1'b1}) begin
      fails++;
      $display("FAIL one_entry_swap: got valid=%b sum=%h cout=%b expected 1 6 1",
               bus.res_valid, bus.res_sum, bus.res_cout);
    end
    pop_one();
    tests++;
    if ({bus.res_valid, bus.overrun} !== 2'b00) begin
      fails++;
      $display("FAIL one_entry_drain: got valid=%b ovr=%b expected 0 0", bus.res_valid, bus.overrun);
    end
  endtask

  task automatic test_abort();
    logic [5:0] bits;
    bits = 6'b111001; // stream 1,0 then 0,1,1,1 read from bit 0 upward
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.bit_valid = 1'b1;
      bus.sum_bit   = bits[i];
      tick();
    end
    // restart with a coincident strobe that must be ignored
    bus.start     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.sum_bit   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 2; i < 6; i++) begin
      bus.bit_valid = 1'b1;
      bus.sum_bit   = bits[i];
      tick();
      if (i == 3) begin
        bus.bit_valid = 1'b0;
        bus.sum_bit   = 1'b0;
        tick();
        tests++;
        if ({bus.busy, bus.res_valid} !== 2'b10) begin
          fails++;
          $display("FAIL abort_gap: got busy=%b valid=%b expected 1 0", bus.busy, bus.res_valid);
        end
      end
    end
    bus.bit_valid = 1'b0;
    bus.sum_bit   = 1'b0;
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.busy, bus.overrun} !== {1'b1, 4'hE, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_result: got valid=%b sum=%h busy=%b ovr=%b expected 1 e 0 0",
               bus.res_valid, bus.res_sum, bus.busy, bus.overrun);
    end
    pop_one();
    tests++;
    if (bus.res_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_single: got valid=%b expected 0", bus.res_valid);
    end
  endtask

  task automatic test_async_reset();
    send(4'hA, 1'b1, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.bit_valid = 1'b1;
    bus.sum_bit   = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    bus.sum_bit   = 1'b0;
    tests++;
    if ({bus.res_valid, bus.busy} !== 2'b11) begin
      fails++;
      $display("FAIL pre_reset: got valid=%b busy=%b expected 1 1", bus.res_valid, bus.busy);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout, bus.busy, bus.overrun} !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: got valid=%b sum=%h cout=%b busy=%b ovr=%b expected all 0",
               bus.res_valid, bus.res_sum, bus.res_cout, bus.busy, bus.overrun);
    end
    #2 reset = 1'b1;
    tick();
    send(4'hB, 1'b0, 1'b0);
    tests++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout} !== {1'b1, 4'hB, 1'b0}) begin
      fails++;
      $display("FAIL post_reset_add: got valid=%b sum=%h cout=%b expected 1 b 0",
               bus.res_valid, bus.res_sum, bus.res_cout);
    end
    pop_one();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add_5_6();
    test_add_9_8();
    test_backpressure();
    test_full_pop();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_sum_collector.md
# serial_sum_collector

Downstream companion to the bit-serial adder. It samples the adder's serial sum stream (LSB first) and its carry, assembles each WIDTH-bit result into a parallel word, and presents completed results through a 2-entry valid/ready output queue. The adder can therefore start the next addition while the consumer is still holding off.

## Interface
Parameters:
- WIDTH, 4, operand/result width in bits (≥2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- start  input  1  one-cycle pulse: a new addition begins; clears partial collection
- bit_valid  input  1  strobe: sum_bit/carry_bit hold the next result bit this cycle
- sum_bit  input  1  serial sum bit, LSB first
- carry_bit  input  1  adder carry-out for the current bit position
- res_ready  input  1  consumer accepts head result this cycle
- clr_err  input  1  synchronous clear of overrun
- res_valid  output  1  queue non-empty; head result on res_sum/res_cout
- res_sum  output  WIDTH  head result sum
- res_cout  output  1  head result carry-out (carry out of MSB position)
- busy  output  1  collection in progress (state COLLECT)
- overrun  output  1  sticky: a completed result was dropped because the queue was full

## Operation
- States: IDLE, COLLECT. Bit counter cnt, 0..WIDTH-1. Shift register shreg[WIDTH-1:0].
- IDLE: bit_valid ignored. start → COLLECT, cnt=0, shreg=0.
- COLLECT, bit_valid with cnt<WIDTH-1: shreg = {sum_bit, shreg[WIDTH-1:1]}, cnt++.
- COLLECT, bit_valid with cnt==WIDTH-1 (last bit): push {sum_bit, shreg[WIDTH-1:1]} as sum and carry_bit as cout into the queue; → IDLE. Only the carry on the last bit is kept.
- start in COLLECT: abort. Partial bits are discarded; cnt=0, shreg=0; stay in COLLECT. No error is flagged.
- start and bit_valid in the same cycle: start wins and that bit_valid is ignored.
- Queue: 2-entry FIFO, entries {sum, cout}. Pop when res_valid && res_ready.
- Push while full without a pop in the same cycle: the new result is dropped, overrun=1, and queue contents are unchanged.
- Push while full with a pop in the same cycle: both proceed and nothing is lost.
- Push and pop in the same cycle with 1 entry: the count stays 1 and the head becomes the new result.
- res_sum/res_cout are don't-care-free: when the queue is empty they read 0.
- overrun is cleared by clr_err or reset. If clr_err and a new overrun occur in the same cycle, the set wins.

## Timing
- Reset values: res_valid=0, res_sum=0, res_cout=0, busy=0, overrun=0; state IDLE, queue empty, cnt=0.
- Reset is asynchronous. Asserted mid-collection, it discards the partial result and the queue contents at once.
- busy rises the cycle after start is sampled. It falls the cycle after the last bit is sampled.
- Latency: res_valid=1 in the cycle after the edge that samples the last bit, provided the queue was empty. There is no extra pipeline stage.
- Throughput: one result per WIDTH+1 cycles (start + WIDTH bits) is sustained with res_ready held high.
- The head updates on the edge of a pop. res_valid stays high if a second entry exists.
- Handshake: res_sum/res_cout are stable while res_valid=1 && res_ready=0.
- Gaps between bit_valid strobes are allowed; cnt holds during gaps.

## Test plan
- WIDTH=4, 5+6. Stimulus: start, then bits 1,1,0,1 on consecutive bit_valid, carry_bit=0 on the last bit. Required: res_valid the next cycle, res_sum=4'hB, res_cout=0, busy low.
- 9+8. Stimulus: bits 1,0,0,0, carry_bit=1 on the last bit. Required: res_sum=4'h1, res_cout=1. Then pulse res_ready. Required: res_valid=0 the next cycle.
- Backpressure. Stimulus: three back-to-back additions (3, 7, 12) with res_ready=0. Required: res_valid=1, queue holds 3 then 7, overrun=1, 12 dropped. Pop twice. Required: 3, then 7, then res_valid=0. Pulse clr_err. Required: overrun=0.
- Full queue with a simultaneous pop. Stimulus: queue holds A, B; the last bit of C arrives with res_ready=1. Required: overrun stays 0, head becomes B, then C.
- Abort. Stimulus: start, bits 1,0, start again, then bits 0,1,1,1. Required: a single result res_sum=4'hE.
- Reset. Stimulus: assert reset mid-collection and between clock edges with one result queued. Required: all outputs go to 0 immediately. After release, a fresh 5+6 still yields 4'hB.
